if_stage: RTL

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC and the IF/ID pipeline register and feeds the instruction word whose op/func fields the ID-stage control decoder consumes. It resolves next-PC for beq/j/jal/jr using branch-delay-slot semantics. Branch and jump decode flags and forwarded register values arrive from ID. Fetch waits are absorbed by a ready-qualified instruction-memory port with a one-entry pending-redirect register.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/if_stage_npc.sv | 46 ++++
 rtl/if_stage.sv | 85 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: reset vector, nop encoding, instruction field positions
// and the IF/ID pipeline register layout.
package cpu_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Instruction field slice positions, shared with the ID-stage decoder
    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int IDX_HI = 25;
    localparam int IDX_LO = 0;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

    // Branch displacement: sign-extended word offset converted to bytes
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_npc.sv
// Next-PC resolution for the instruction sitting in IF/ID: computes the
// redirect target for beq/j/jal/jr and whether the redirect is taken.
module npc
    import cpu_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [25:0] i_index,
    input  logic        i_valid,
    input  logic        i_stall,
    input  logic        i_beq,
    input  logic        i_j,
    input  logic        i_jal,
    input  logic        i_jr,
    input  logic [31:0] i_rs_val,
    input  logic [31:0] i_rt_val,
    output logic [31:0] o_target,
    output logic        o_taken
);

    logic [31:0] w_pc4;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;
    logic        w_equal;

    assign w_pc4           = i_pc + 32'd4;
    assign w_jump_target   = {w_pc4[31:28], i_index, 2'b00};
    assign w_branch_target = w_pc4 + branch_offset(i_index[IMM_HI:IMM_LO]);
    assign w_equal         = (i_rs_val == i_rt_val);

    // Target select: jr uses the register value unaligned, j/jal the pseudo-direct form
    always_comb begin
        o_target = w_branch_target;
        if (i_jr) begin
            o_target = i_rs_val;
        end else if (i_j || i_jal) begin
            o_target = w_jump_target;
        end
    end

    // A stalled or bubble IF/ID slot can never redirect
    always_comb begin
        o_taken = i_valid && !i_stall &&
                  (i_j || i_jal || i_jr || (i_beq && w_equal));
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, IF/ID register and a one-entry pending redirect
// that holds a branch target while instruction memory is not ready.
module if_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        id_stall,
    input  logic        id_beq,
    input  logic        id_j,
    input  logic        id_jal,
    input  logic        id_jr,
    input  logic [31:0] id_rs_val,
    input  logic [31:0] id_rt_val,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc8,
    output logic        if_id_valid
);

    logic [31:0] r_pc;
    if_id_t      r_if_id;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;

    logic [31:0] w_target;
    logic        w_taken;

    npc u_npc (
        .i_pc     (r_if_id.pc),
        .i_index  (r_if_id.instr[IDX_HI:IDX_LO]),
        .i_valid  (r_if_id.valid),
        .i_stall  (id_stall),
        .i_beq    (id_beq),
        .i_j      (id_j),
        .i_jal    (id_jal),
        .i_jr     (id_jr),
        .i_rs_val (id_rs_val),
        .i_rt_val (id_rt_val),
        .o_target (w_target),
        .o_taken  (w_taken)
    );

    // PC / IF/ID / pending update; a stall freezes everything, the delay slot
    // always enters IF/ID and the redirect applies to the following fetch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_if_id       <= '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0};
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'h0;
        end else if (!id_stall) begin
            if (imem_ready) begin
                r_if_id <= '{instr: imem_rdata, pc: r_pc, valid: 1'b1};
                if (r_pend_valid) begin
                    r_pc         <= r_pend_target;
                    r_pend_valid <= 1'b0;
                end else if (w_taken) begin
                    r_pc <= w_target;
                end else begin
                    r_pc <= r_pc + 32'd4;
                end
            end else begin
                r_if_id <= '{instr: NOP_INSTR, pc: r_pc, valid: 1'b0};
                if (w_taken) begin
                    r_pend_valid  <= 1'b1;
                    r_pend_target <= w_target;
                end
            end
        end
    end

    // A pending redirect means IF/ID holds a bubble, so no new redirect may arrive
    assert property (@(posedge clk) disable iff (!reset_n) !(r_pend_valid && w_taken));

    assign imem_addr   = r_pc;
    assign if_id_instr = r_if_id.instr;
    assign if_id_pc    = r_if_id.pc;
    assign if_id_valid = r_if_id.valid;
    assign if_id_pc8   = r_if_id.pc + 32'd8;

endmodule
